// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : MEM pipeline stage. Consumes the EX/MEM register outputs,
//               performs loads/stores over a req/ack data-memory bus, stalls
//               the upstream pipeline while an access is outstanding, and
//               registers the MEM/WB outputs. Bubbles are inserted while the
//               stage is busy or an access is dropped. Misaligned addresses
//               and bus timeouts each raise a one-cycle error pulse.
// Ports       :
//   clk, reset (async, active-low)
//   EX/MEM in  : MemRead_in, MemWrite_in, MemToReg_in, RegWrite_in,
//                ALUResult_in, RD2_in, WriteReg_in
//   stall      : combinational freeze of EX/MEM and earlier stages
//   Bus        : mem_req, mem_we, mem_addr, mem_wdata (registered),
//                mem_ack, mem_rdata
//   MEM/WB out : RegWrite_out, MemToReg_out, ReadData_out, ALUResult_out,
//                WriteReg_out
//   Errors     : err_misalign, err_timeout (one-cycle registered pulses)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int ADDR_W         = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              MemRead_in,
   input  logic              MemWrite_in,
   input  logic              MemToReg_in,
   input  logic              RegWrite_in,
   input  logic [31:0]       ALUResult_in,
   input  logic [31:0]       RD2_in,
   input  logic [4:0]        WriteReg_in,
   output logic              stall,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic              mem_ack,
   input  logic [31:0]       mem_rdata,
   output logic              RegWrite_out,
   output logic              MemToReg_out,
   output logic [31:0]       ReadData_out,
   output logic [31:0]       ALUResult_out,
   output logic [4:0]        WriteReg_out,
   output logic              err_misalign,
   output logic              err_timeout
);

   // One extra bit keeps TIMEOUT_CYCLES-1 representable for every legal value.
   localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                mem_req_q, mem_req_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [31:0]         mem_wdata_q, mem_wdata_d;
   logic                regwrite_q, regwrite_d;
   logic                memtoreg_q, memtoreg_d;
   logic [31:0]         readdata_q, readdata_d;
   logic [31:0]         aluresult_q, aluresult_d;
   logic [4:0]          writereg_q, writereg_d;
   logic                err_misalign_q, err_misalign_d;
   logic                err_timeout_q, err_timeout_d;

   logic                access;
   logic                misaligned;
   logic [ADDR_W-1:0]   addr_in;

   assign access     = MemRead_in | MemWrite_in;
   assign misaligned = |ALUResult_in[1:0];

   // Fit the 32-bit effective address onto the bus address width.
   generate
      if (ADDR_W > 32) begin : g_addr_wide
         assign addr_in = {{(ADDR_W-32){1'b0}}, ALUResult_in};
      end else begin : g_addr_narrow
         assign addr_in = ALUResult_in[ADDR_W-1:0];
      end
   endgenerate

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      mem_req_d      = mem_req_q;
      mem_we_d       = mem_we_q;
      mem_addr_d     = mem_addr_q;
      mem_wdata_d    = mem_wdata_q;
      // MEM/WB defaults to a bubble; paths that retire an instruction
      // override the control bits.
      regwrite_d     = 1'b0;
      memtoreg_d     = 1'b0;
      readdata_d     = 32'h0;
      aluresult_d    = ALUResult_in;
      writereg_d     = WriteReg_in;
      err_misalign_d = 1'b0;
      err_timeout_d  = 1'b0;
      stall          = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (!access) begin
               regwrite_d = RegWrite_in;
               memtoreg_d = MemToReg_in;
            end else if (misaligned) begin
               // Dropped without a bus cycle; the pipeline keeps moving.
               err_misalign_d = 1'b1;
            end else begin
               stall       = 1'b1;
               state_d     = S_WAIT;
               cnt_d       = '0;
               mem_req_d   = 1'b1;
               mem_we_d    = MemWrite_in;  // read+write together acts as a write
               mem_addr_d  = addr_in;
               mem_wdata_d = RD2_in;
            end
         end

         S_WAIT: begin
            // Ack has priority over timeout when both land in one cycle.
            if (mem_ack) begin
               state_d    = S_IDLE;
               mem_req_d  = 1'b0;
               regwrite_d = RegWrite_in;
               memtoreg_d = MemToReg_in;
               readdata_d = mem_we_q ? 32'h0 : mem_rdata;
            end else if (cnt_q == CNT_LAST) begin
               // Release the pipeline on the last cycle and drop the access.
               state_d       = S_IDLE;
               mem_req_d     = 1'b0;
               err_timeout_d = 1'b1;
            end else begin
               stall = 1'b1;
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         default: begin
            state_d   = S_IDLE;
            mem_req_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= S_IDLE;
         cnt_q          <= '0;
         mem_req_q      <= 1'b0;
         mem_we_q       <= 1'b0;
         mem_addr_q     <= '0;
         mem_wdata_q    <= 32'h0;
         regwrite_q     <= 1'b0;
         memtoreg_q     <= 1'b0;
         readdata_q     <= 32'h0;
         aluresult_q    <= 32'h0;
         writereg_q     <= 5'h0;
         err_misalign_q <= 1'b0;
         err_timeout_q  <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         mem_req_q      <= mem_req_d;
         mem_we_q       <= mem_we_d;
         mem_addr_q     <= mem_addr_d;
         mem_wdata_q    <= mem_wdata_d;
         regwrite_q     <= regwrite_d;
         memtoreg_q     <= memtoreg_d;
         readdata_q     <= readdata_d;
         aluresult_q    <= aluresult_d;
         writereg_q     <= writereg_d;
         err_misalign_q <= err_misalign_d;
         err_timeout_q  <= err_timeout_d;
      end
   end

   assign mem_req       = mem_req_q;
   assign mem_we        = mem_we_q;
   assign mem_addr      = mem_addr_q;
   assign mem_wdata     = mem_wdata_q;
   assign RegWrite_out  = regwrite_q;
   assign MemToReg_out  = memtoreg_q;
   assign ReadData_out  = readdata_q;
   assign ALUResult_out = aluresult_q;
   assign WriteReg_out  = writereg_q;
   assign err_misalign  = err_misalign_q;
   assign err_timeout   = err_timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Directed self-checking bench for mem_access_unit with
//               TIMEOUT_CYCLES = 4. Inputs change 2 time units after each
//               rising edge; combinational stall is checked 1 unit later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        MemRead_in, MemWrite_in, MemToReg_in, RegWrite_in;
   logic [31:0] ALUResult_in, RD2_in;
   logic [4:0]  WriteReg_in;
   logic        stall, mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        RegWrite_out, MemToReg_out;
   logic [31:0] ReadData_out, ALUResult_out;
   logic [4:0]  WriteReg_out;
   logic        err_misalign, err_timeout;

   int passed = 0;
   int total  = 0;

   mem_access_unit #(.TIMEOUT_CYCLES(4), .ADDR_W(32)) dut (
      .clk(clk), .reset(reset),
      .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
      .MemToReg_in(MemToReg_in), .RegWrite_in(RegWrite_in),
      .ALUResult_in(ALUResult_in), .RD2_in(RD2_in), .WriteReg_in(WriteReg_in),
      .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .RegWrite_out(RegWrite_out), .MemToReg_out(MemToReg_out),
      .ReadData_out(ReadData_out), .ALUResult_out(ALUResult_out),
      .WriteReg_out(WriteReg_out),
      .err_misalign(err_misalign), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "bench did not finish");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic set_in(input logic rd, input logic wr, input logic m2r, input logic rw,
                         input logic [31:0] alu, input logic [31:0] rd2, input logic [4:0] wreg);
      MemRead_in   = rd;
      MemWrite_in  = wr;
      MemToReg_in  = m2r;
      RegWrite_in  = rw;
      ALUResult_in = alu;
      RD2_in       = rd2;
      WriteReg_in  = wreg;
   endtask

   initial begin
      reset     = 1'b0;
      mem_ack   = 1'b1;
      mem_rdata = 32'h0;
      set_in(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);

      // ---- reset held 3 cycles with ack high ----
      repeat (3) tick();
      #1;
      chk("rst_stall",    stall, 0);
      chk("rst_req",      mem_req, 0);
      chk("rst_we",       mem_we, 0);
      chk("rst_addr",     mem_addr, 0);
      chk("rst_wdata",    mem_wdata, 0);
      chk("rst_regwr",    RegWrite_out, 0);
      chk("rst_m2r",      MemToReg_out, 0);
      chk("rst_rdata",    ReadData_out, 0);
      chk("rst_alu",      ALUResult_out, 0);
      chk("rst_wreg",     WriteReg_out, 0);
      chk("rst_errmis",   err_misalign, 0);
      chk("rst_errto",    err_timeout, 0);
      reset   = 1'b1;
      mem_ack = 1'b0;
      tick();
      chk("post_rst_req", mem_req, 0);

      // ---- non-memory pass-through ----
      set_in(0, 0, 0, 1, 32'h0000_1234, 32'h0, 5'd9);
      #1 chk("nop_stall", stall, 0);
      tick();
      chk("nop_regwr", RegWrite_out, 1);
      chk("nop_alu",   ALUResult_out, 32'h1234);
      chk("nop_wreg",  WriteReg_out, 9);
      chk("nop_rdata", ReadData_out, 0);

      // ---- load, ack on 3rd WAIT cycle ----
      set_in(1, 0, 1, 1, 32'h0000_0100, 32'h0, 5'd3);
      #1 chk("ld_stall_idle", stall, 1);
      tick();                                   // WAIT 1
      chk("ld_req",    mem_req, 1);
      chk("ld_we",     mem_we, 0);
      chk("ld_addr",   mem_addr, 32'h100);
      chk("ld_bub1",   RegWrite_out, 0);
      #1 chk("ld_stall_w1", stall, 1);
      tick();                                   // WAIT 2
      chk("ld_bub2",   RegWrite_out, 0);
      chk("ld_req_w2", mem_req, 1);
      #1 chk("ld_stall_w2", stall, 1);
      tick();                                   // WAIT 3 with ack
      mem_ack   = 1'b1;
      mem_rdata = 32'hDEAD_BEEF;
      #1 chk("ld_stall_ack", stall, 0);
      tick();
      chk("ld_rdata",  ReadData_out, 32'hDEAD_BEEF);
      chk("ld_m2r",    MemToReg_out, 1);
      chk("ld_regwr",  RegWrite_out, 1);
      chk("ld_wreg",   WriteReg_out, 3);
      chk("ld_req_off", mem_req, 0);

      // ---- store, ack on first WAIT cycle, then back-to-back load ----
      mem_ack = 1'b0;
      set_in(0, 1, 0, 0, 32'h0000_0204, 32'hCAFE_0001, 5'd0);
      #1 chk("st_stall_idle", stall, 1);
      tick();
      chk("st_req",   mem_req, 1);
      chk("st_we",    mem_we, 1);
      chk("st_addr",  mem_addr, 32'h204);
      chk("st_wdata", mem_wdata, 32'hCAFE_0001);
      mem_ack   = 1'b1;
      mem_rdata = 32'h1234_5678;
      #1 chk("st_stall_ack", stall, 0);
      tick();
      chk("st_rdata", ReadData_out, 0);
      mem_ack = 1'b0;
      set_in(1, 0, 1, 1, 32'h0000_0300, 32'h0, 5'd4);
      chk("b2b_gap",  mem_req, 0);
      #1 chk("b2b_stall", stall, 1);
      tick();
      chk("b2b_req",  mem_req, 1);
      chk("b2b_addr", mem_addr, 32'h300);
      mem_ack   = 1'b1;
      mem_rdata = 32'h0BAD_F00D;
      tick();
      chk("b2b_rdata", ReadData_out, 32'h0BAD_F00D);
      chk("b2b_req_off", mem_req, 0);

      // ---- misaligned load, then ack while IDLE ----
      mem_ack = 1'b0;
      set_in(1, 0, 1, 1, 32'h0000_0102, 32'h0, 5'd7);
      #1 chk("mis_stall", stall, 0);
      tick();
      chk("mis_err",   err_misalign, 1);
      chk("mis_req",   mem_req, 0);
      chk("mis_regwr", RegWrite_out, 0);
      chk("mis_m2r",   MemToReg_out, 0);
      chk("mis_alu",   ALUResult_out, 32'h102);
      set_in(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
      mem_ack = 1'b1;
      tick();
      chk("mis_pulse", err_misalign, 0);
      chk("idle_ack_req", mem_req, 0);

      // ---- timeout: never ack ----
      mem_ack = 1'b0;
      set_in(1, 0, 1, 1, 32'h0000_0400, 32'h0, 5'd5);
      tick();                                   // WAIT cnt 0
      #1 chk("to_stall_w1", stall, 1);
      tick();
      #1 chk("to_stall_w2", stall, 1);
      tick();
      #1 chk("to_stall_w3", stall, 1);
      tick();
      #1 chk("to_stall_w4", stall, 0);
      chk("to_req_w4", mem_req, 1);
      tick();
      chk("to_err",    err_timeout, 1);
      chk("to_req",    mem_req, 0);
      chk("to_regwr",  RegWrite_out, 0);
      set_in(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
      tick();
      chk("to_pulse",  err_timeout, 0);

      // ---- ack on the 4th WAIT cycle beats the timeout ----
      set_in(1, 0, 1, 1, 32'h0000_0500, 32'h0, 5'd6);
      repeat (4) tick();                        // now in WAIT cnt 3
      mem_ack   = 1'b1;
      mem_rdata = 32'h55AA_55AA;
      #1 chk("ack4_stall", stall, 0);
      tick();
      chk("ack4_noerr", err_timeout, 0);
      chk("ack4_rdata", ReadData_out, 32'h55AA_55AA);
      chk("ack4_regwr", RegWrite_out, 1);

      // ---- asynchronous reset in the middle of WAIT ----
      mem_ack = 1'b0;
      set_in(1, 0, 1, 1, 32'h0000_0600, 32'h0, 5'd8);
      tick();
      chk("arst_req_pre", mem_req, 1);
      reset = 1'b0;
      #1 chk("arst_req_drop", mem_req, 0);
      chk("arst_alu", ALUResult_out, 0);
      mem_ack = 1'b1;
      tick();
      reset = 1'b1;
      set_in(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
      tick();
      chk("late_ack_req", mem_req, 0);
      chk("late_ack_rdata", ReadData_out, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
